// File: rtl/hazard_unit.sv
// RV32I hazard controller: tracks EX/MEM destinations, selects operand forwarding,
// inserts a load-use bubble and squashes wrong-path ID slots after a taken branch.

module hazard_src #(
  parameter int NB_OPERAND = 5
) (
  input  logic [NB_OPERAND-1:0] i_rs,
  input  logic                  i_uses,
  input  logic                  i_ex_valid,
  input  logic [NB_OPERAND-1:0] i_ex_rd,
  input  logic                  i_ex_rw,
  input  logic                  i_ex_load,
  input  logic                  i_mem_valid,
  input  logic [NB_OPERAND-1:0] i_mem_rd,
  input  logic                  i_mem_rw,
  output logic [1:0]            o_fwd,
  output logic                  o_load_use
);
  logic w_ex_hit, w_mem_hit;

  assign w_ex_hit  = i_uses && i_ex_valid && i_ex_rw && (i_ex_rd != '0) && (i_ex_rd == i_rs);
  assign w_mem_hit = i_uses && i_mem_valid && i_mem_rw && (i_mem_rd != '0) && (i_mem_rd == i_rs);
  assign o_load_use = w_ex_hit && i_ex_load;

  // A load in EX shadows any older MEM match: the select stays RF until the load reaches MEM.
  always_comb begin
    o_fwd = 2'b00;
    if (w_ex_hit)       o_fwd = i_ex_load ? 2'b00 : 2'b01;
    else if (w_mem_hit) o_fwd = 2'b10;
  end
endmodule

module hazard_unit #(
  parameter int NB_OPERAND   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int NB_STALL_CNT = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_id_valid,
  input  logic [NB_OPERAND-1:0]   i_id_rs1,
  input  logic [NB_OPERAND-1:0]   i_id_rs2,
  input  logic                    i_id_uses_rs1,
  input  logic                    i_id_uses_rs2,
  input  logic [NB_OPERAND-1:0]   i_id_rd,
  input  logic                    i_id_reg_write,
  input  logic                    i_id_is_load,
  input  logic                    i_branch_taken,
  output logic [1:0]              o_forward_rs1,
  output logic [1:0]              o_forward_rs2,
  output logic                    o_stall,
  output logic                    o_ex_bubble,
  output logic                    o_flush,
  output logic [NB_STALL_CNT-1:0] o_stall_count,
  output logic [NB_STALL_CNT-1:0] o_flush_count
);
  localparam int NSRC = 2;

  logic                  r_ex_valid, r_ex_rw, r_ex_load;
  logic [NB_OPERAND-1:0] r_ex_rd;
  logic                  r_mem_valid, r_mem_rw;
  logic [NB_OPERAND-1:0] r_mem_rd;
  logic [2:0]            r_fcnt;
  logic [NB_STALL_CNT-1:0] r_stall_cnt, r_flush_cnt;

  logic [NSRC-1:0][NB_OPERAND-1:0] w_rs;
  logic [NSRC-1:0]                 w_uses;
  logic [NSRC-1:0][1:0]            w_fwd;
  logic [NSRC-1:0]                 w_lu;
  logic                            w_load_use;

  assign w_rs   = {i_id_rs2, i_id_rs1};
  assign w_uses = {i_id_uses_rs2, i_id_uses_rs1};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_src #(.NB_OPERAND(NB_OPERAND)) u_src (
      .i_rs       (w_rs[g]),
      .i_uses     (w_uses[g]),
      .i_ex_valid (r_ex_valid),
      .i_ex_rd    (r_ex_rd),
      .i_ex_rw    (r_ex_rw),
      .i_ex_load  (r_ex_load),
      .i_mem_valid(r_mem_valid),
      .i_mem_rd   (r_mem_rd),
      .i_mem_rw   (r_mem_rw),
      .o_fwd      (w_fwd[g]),
      .o_load_use (w_lu[g])
    );
  end

  assign o_forward_rs1 = w_fwd[0];
  assign o_forward_rs2 = w_fwd[1];
  assign w_load_use    = |w_lu && i_id_valid;
  assign o_flush       = i_branch_taken || (r_fcnt != 3'd0);
  assign o_stall       = w_load_use && !o_flush;
  assign o_ex_bubble   = o_flush || w_load_use;
  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_rd    <= '0;
      r_fcnt      <= 3'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_rw    <= r_ex_rw;
      r_mem_rd    <= r_ex_rd;
      r_ex_valid  <= o_ex_bubble ? 1'b0 : i_id_valid;
      r_ex_rw     <= i_id_reg_write;
      r_ex_load   <= i_id_is_load;
      r_ex_rd     <= i_id_rd;
      if (i_branch_taken)      r_fcnt <= 3'(FLUSH_CYCLES - 1);
      else if (r_fcnt != 3'd0) r_fcnt <= r_fcnt - 3'd1;
      if (o_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + NB_STALL_CNT'(1);
      if (o_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + NB_STALL_CNT'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each driven cycle pushes its expected outputs,
// which are popped and compared half a cycle later.

module tb_hazard_unit;
  localparam int NB = 5;
  localparam int NC = 4;

  logic          clk, rst_n;
  logic          id_valid, uses1, uses2, rw, ld, br;
  logic [NB-1:0] rs1, rs2, rd;
  logic [1:0]    fwd1, fwd2;
  logic          stall, bubble, flush;
  logic [NC-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic       st;
    logic       bub;
    logic       fl;
  } exp_t;

  exp_t sb[$];
  int   n_vec, n_err;

  hazard_unit #(.NB_OPERAND(NB), .FLUSH_CYCLES(2), .NB_STALL_CNT(NC)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs1      (rs1),
    .i_id_rs2      (rs2),
    .i_id_uses_rs1 (uses1),
    .i_id_uses_rs2 (uses2),
    .i_id_rd       (rd),
    .i_id_reg_write(rw),
    .i_id_is_load  (ld),
    .i_branch_taken(br),
    .o_forward_rs1 (fwd1),
    .o_forward_rs2 (fwd2),
    .o_stall       (stall),
    .o_ex_bubble   (bubble),
    .o_flush       (flush),
    .o_stall_count (stall_cnt),
    .o_flush_count (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] f1, input logic [1:0] f2,
                              input logic st, input logic bub, input logic fl);
    mk = '{f1: f1, f2: f2, st: st, bub: bub, fl: fl};
  endfunction

  // One cycle: drive after the edge, compare combinational outputs on the falling edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [NB-1:0] s1, input logic u1,
                      input logic [NB-1:0] s2, input logic u2,
                      input logic [NB-1:0] d, input logic w, input logic l,
                      input logic b, input exp_t e);
    exp_t got;
    @(posedge clk); #1;
    rst_n = r; id_valid = v; rs1 = s1; uses1 = u1; rs2 = s2; uses2 = u2;
    rd = d; rw = w; ld = l; br = b;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk({tag, ".fwd1"},  int'(fwd1),   int'(got.f1));
    chk({tag, ".fwd2"},  int'(fwd2),   int'(got.f2));
    chk({tag, ".stall"}, int'(stall),  int'(got.st));
    chk({tag, ".bub"},   int'(bubble), int'(got.bub));
    chk({tag, ".flush"}, int'(flush),  int'(got.fl));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; id_valid = 1'b0; rs1 = '0; rs2 = '0; uses1 = 1'b0; uses2 = 1'b0;
    rd = '0; rw = 1'b0; ld = 1'b0; br = 1'b0;

    step("rst0", 0, 1, 5, 1, 5, 1, 5, 1, 1, 0, mk(0, 0, 0, 0, 0));
    step("rst1", 0, 1, 5, 1, 5, 1, 5, 1, 1, 0, mk(0, 0, 0, 0, 0));
    chk("rst.scnt", int'(stall_cnt), 0);
    chk("rst.fcnt", int'(flush_cnt), 0);

    // Forwarding: ADD x5 then ADD x5, with priority of EX over MEM.
    step("add5",   1, 1, 0, 0, 0, 0, 5, 1, 0, 0, mk(0, 0, 0, 0, 0));
    step("ex_rs1", 1, 1, 5, 1, 6, 1, 5, 1, 0, 0, mk(1, 0, 0, 0, 0));
    step("ex_pri", 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0));
    step("mem_rs2",1, 1, 0, 0, 5, 1, 7, 1, 1, 0, mk(0, 2, 0, 0, 0));

    // Load-use on x7: one bubble, then forward from MEM.
    step("lu_c0",  1, 1, 7, 1, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 0));
    step("lu_c1",  1, 1, 7, 1, 0, 0, 0, 1, 0, 0, mk(2, 0, 0, 0, 0));
    chk("lu.scnt", int'(stall_cnt), 1);

    // x0 writer and non-writer never forward.
    step("x0",     1, 1, 0, 1, 0, 1, 9, 0, 0, 0, mk(0, 0, 0, 0, 0));
    step("norw",   1, 1, 9, 1, 9, 1, 8, 1, 1, 0, mk(0, 0, 0, 0, 0));

    // Branch with a simultaneous load-use: flush wins for two slots.
    step("br_c0",  1, 1, 8, 1, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 1, 1));
    step("br_c1",  1, 1, 8, 1, 0, 0, 0, 0, 0, 0, mk(2, 0, 0, 1, 1));
    chk("br.exv1", int'(dut.r_ex_valid), 0);
    step("br_c2",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));
    chk("br.exv2", int'(dut.r_ex_valid), 0);
    chk("br.fcnt", int'(flush_cnt), 2);
    chk("br.scnt", int'(stall_cnt), 1);

    // Reset in the middle of a flush.
    step("rf_br",  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 1, 1));
    step("rf_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 1, 1));
    step("rf_post",1, 1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));
    chk("rf.fcnt", int'(flush_cnt), 0);
    chk("rf.scnt", int'(stall_cnt), 0);

    // Twenty load-use stalls against a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step("sat_ld", 1, 1, 0, 0, 0, 0, 3, 1, 1, 0, mk(0, 0, 0, 0, 0));
      step("sat_lu", 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 0));
    end
    @(negedge clk);
    chk("sat.scnt", int'(stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
